// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_pkg
//  Description : Shared encodings for the RV32M multiply/divide unit:
//                func3 operation codes, M-extension func7 and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // DIV and REM treat operands as two's complement; DIVU and REMU do not.
    function automatic logic div_is_signed(input logic [2:0] func3);
        return ~func3[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_if
//  Description : Issue / stall / writeback bundle between execute, ctrl and
//                the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            hold_flag_o;
    logic            busy_o;
    logic            rd_wen_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] rd_data_o;

    // Pipeline side: issues ops and flushes, consumes stall and writeback.
    modport master (
        output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  hold_flag_o, busy_o, rd_wen_o, rd_addr_o, rd_data_o
    );

    // Unit side.
    modport slave (
        input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        output hold_flag_o, busy_o, rd_wen_o, rd_addr_o, rd_data_o
    );

endinterface
`default_nettype wire

// File: rtl/ex_muldiv_div_radix2.sv
`default_nettype none
// ============================================================================
//  Module      : div_radix2
//  Description : Iterative restoring radix-2 unsigned divider, one quotient
//                bit per cycle. The last iteration is presented
//                combinationally together with done so the caller can
//                register the final result on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_radix2 #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            start,
    input  wire logic            abort,
    input  wire logic [XLEN-1:0] dividend,
    input  wire logic [XLEN-1:0] divisor,
    output logic      [XLEN-1:0] quotient,
    output logic      [XLEN-1:0] remainder,
    output logic                 done
);

    localparam int            CW        = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    logic            busy;
    logic [CW-1:0]   iter;
    logic [XLEN-1:0] quo;      // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsr;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] rem_next;

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

    // Iteration registers; abort drops the operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            iter <= '0;
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            iter <= '0;
        end else if (start) begin
            busy <= 1'b1;
            iter <= '0;
            quo  <= dividend;
            rem  <= '0;
            dsr  <= divisor;
        end else if (busy) begin
            quo <= quo_next;
            rem <= rem_next;
            if (iter == LAST_ITER) begin
                busy <= 1'b0;
                iter <= '0;
            end else begin
                iter <= iter + CW'(1);
            end
        end
    end

    assign quotient  = quo_next;
    assign remainder = rem_next;
    assign done      = busy & (iter == LAST_ITER);

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Multi-cycle RV32M multiply/divide unit. Stalls the pipeline
//                while working and returns the result as a one-cycle rd
//                write. Signed handling and divide special cases live here;
//                the unsigned iteration lives in div_radix2.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ex_muldiv_if.slave bus
);

    localparam logic [XLEN-1:0] MOST_NEG     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]      MUL_CNT_INIT = (MUL_LAT >= 2) ? 3'(MUL_LAT - 2) : 3'd0;

    md_state_e         state;
    md_state_e         state_next;
    logic              accept;

    logic [2:0]        func3_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   op2_q;
    logic [4:0]        rd_addr_q;
    logic              neg_quo;
    logic              neg_rem;
    logic [2:0]        mul_cnt;
    logic [XLEN-1:0]   result_q;

    logic [2:0]        f_sel;
    logic [XLEN-1:0]   a_sel;
    logic [XLEN-1:0]   b_sel;

    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_result;

    logic              is_div;
    logic              div_signed;
    logic              div_by_zero;
    logic              div_overflow;
    logic              div_special;
    logic [XLEN-1:0]   special_result;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic              div_start;
    logic              div_done;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   div_result;

    assign accept = bus.start_i & (state == MD_IDLE) & ~bus.flush_i;

    // In IDLE the operation is still on the issue port; afterwards use the latched copy.
    assign f_sel = (state == MD_IDLE) ? bus.func3_i : func3_q;
    assign a_sel = (state == MD_IDLE) ? bus.op1_i   : op1_q;
    assign b_sel = (state == MD_IDLE) ? bus.op2_i   : op2_q;

    // Extending to 2*XLEN and keeping the low 2*XLEN product bits equals the
    // (XLEN+1)-bit signed/unsigned product for every MUL* flavour.
    assign mul_a      = {{XLEN{(f_sel != INST_MULHU) & a_sel[XLEN-1]}}, a_sel};
    assign mul_b      = {{XLEN{(f_sel == INST_MULH)  & b_sel[XLEN-1]}}, b_sel};
    assign product    = mul_a * mul_b;
    assign mul_result = (f_sel == INST_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    assign is_div         = f_sel[2];
    assign div_signed     = div_is_signed(f_sel);
    assign div_by_zero    = (b_sel == '0);
    assign div_overflow   = div_signed & (a_sel == MOST_NEG) & (b_sel == '1);
    assign div_special    = div_by_zero | div_overflow;
    assign special_result = f_sel[1] ? (div_by_zero ? a_sel : '0)
                                     : (div_by_zero ? '1    : a_sel);

    assign a_neg = div_signed & a_sel[XLEN-1];
    assign b_neg = div_signed & b_sel[XLEN-1];
    assign mag_a = a_neg ? -a_sel : a_sel;
    assign mag_b = b_neg ? -b_sel : b_sel;

    assign div_start = accept & is_div & ~div_special;

    div_radix2 #(
        .XLEN (XLEN)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.flush_i),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    assign div_raw    = func3_q[1] ? div_rem : div_quo;
    assign div_result = (func3_q[1] ? neg_rem : neg_quo) ? -div_raw : div_raw;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: flush wins over any progress or completion.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: begin
                if (accept) begin
                    if (!is_div) begin
                        state_next = (MUL_LAT == 1) ? MD_DONE : MD_MUL;
                    end else if (div_special) begin
                        state_next = MD_DONE;
                    end else begin
                        state_next = MD_DIV;
                    end
                end
            end
            MD_MUL: begin
                if (bus.flush_i) begin
                    state_next = MD_IDLE;
                end else if (mul_cnt == 3'd0) begin
                    state_next = MD_DONE;
                end
            end
            MD_DIV: begin
                if (bus.flush_i) begin
                    state_next = MD_IDLE;
                end else if (div_done) begin
                    state_next = MD_DONE;
                end
            end
            default: begin
                state_next = MD_IDLE;
            end
        endcase
    end

    // Operand capture, latency countdown and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func3_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_addr_q <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            mul_cnt   <= '0;
            result_q  <= '0;
        end else if (accept) begin
            func3_q   <= bus.func3_i;
            op1_q     <= bus.op1_i;
            op2_q     <= bus.op2_i;
            rd_addr_q <= bus.rd_addr_i;
            neg_quo   <= a_neg ^ b_neg;
            neg_rem   <= a_neg;
            mul_cnt   <= MUL_CNT_INIT;
            if (!is_div && (MUL_LAT == 1)) begin
                result_q <= mul_result;
            end else if (is_div && div_special) begin
                result_q <= special_result;
            end
        end else if ((state == MD_MUL) && !bus.flush_i) begin
            if (mul_cnt == 3'd0) begin
                result_q <= mul_result;
            end else begin
                mul_cnt <= mul_cnt - 3'd1;
            end
        end else if ((state == MD_DIV) && !bus.flush_i && div_done) begin
            result_q <= div_result;
        end
    end

    assign bus.hold_flag_o = accept | (state == MD_MUL) | (state == MD_DIV);
    assign bus.busy_o      = (state != MD_IDLE);
    assign bus.rd_wen_o    = (state == MD_DONE) & ~bus.flush_i & (rd_addr_q != 5'd0);
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_data_o   = result_q;

endmodule
`default_nettype wire
